// File: rtl/mmu_tlb_if.sv
// Lookup/response, fill and flush channels of the TLB.
// The TLB drives the slave side; the requester drives the master side.
interface mmu_tlb_if #(
  parameter int VPN_WIDTH  = 20,
  parameter int PPN_WIDTH  = 20,
  parameter int ASID_WIDTH = 9
);
  logic                  lookup_valid_i;
  logic                  lookup_ready_o;
  logic [VPN_WIDTH-1:0]  lookup_vpn_i;
  logic [ASID_WIDTH-1:0] lookup_asid_i;
  logic                  lookup_is_write_i;
  logic                  lookup_is_fetch_i;
  logic                  lookup_user_i;

  logic                  resp_valid_o;
  logic                  resp_hit_o;
  logic [PPN_WIDTH-1:0]  resp_ppn_o;
  logic                  resp_fault_o;
  logic [3:0]            resp_fault_type_o;

  logic                  fill_valid_i;
  logic                  fill_ready_o;
  logic [VPN_WIDTH-1:0]  fill_vpn_i;
  logic [PPN_WIDTH-1:0]  fill_ppn_i;
  logic [ASID_WIDTH-1:0] fill_asid_i;
  logic [7:0]            fill_perm_i;

  logic                  flush_valid_i;
  logic                  flush_all_i;
  logic [ASID_WIDTH-1:0] flush_asid_i;
  logic                  flush_done_o;

  modport master (
    output lookup_valid_i, lookup_vpn_i, lookup_asid_i, lookup_is_write_i,
           lookup_is_fetch_i, lookup_user_i,
           fill_valid_i, fill_vpn_i, fill_ppn_i, fill_asid_i, fill_perm_i,
           flush_valid_i, flush_all_i, flush_asid_i,
    input  lookup_ready_o, resp_valid_o, resp_hit_o, resp_ppn_o, resp_fault_o,
           resp_fault_type_o, fill_ready_o, flush_done_o
  );

  modport slave (
    input  lookup_valid_i, lookup_vpn_i, lookup_asid_i, lookup_is_write_i,
           lookup_is_fetch_i, lookup_user_i,
           fill_valid_i, fill_vpn_i, fill_ppn_i, fill_asid_i, fill_perm_i,
           flush_valid_i, flush_all_i, flush_asid_i,
    output lookup_ready_o, resp_valid_o, resp_hit_o, resp_ppn_o, resp_fault_o,
           resp_fault_type_o, fill_ready_o, flush_done_o
  );
endinterface

// File: rtl/mmu_tlb.sv
// Set-associative TLB with permission checks, round-robin replacement and set-walking flush.
// MMU_TLB_ASID_EN enables ASID tags, ASID matching and ASID-selective flush.
module mmu_tlb #(
  parameter int TLB_ENTRIES = 16,
  parameter int TLB_WAYS    = 2,
  parameter int VPN_WIDTH   = 20,
  parameter int PPN_WIDTH   = 20,
  parameter int ASID_WIDTH  = 9
) (
  input  logic     clk_i,
  input  logic     rst_i,
  mmu_tlb_if.slave tlb
);
  localparam int SETS  = TLB_ENTRIES / TLB_WAYS;
  localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 0;
  localparam int SET_W = (IDX_W > 0) ? IDX_W : 1;
  localparam int WAY_W = (TLB_WAYS > 1) ? $clog2(TLB_WAYS) : 1;
  localparam int P_X = 0, P_W = 1, P_R = 2, P_U = 3, P_D = 4, P_G = 5;
`ifdef MMU_TLB_ASID_EN
  localparam int PERM_W = 6;
`else
  localparam int PERM_W = 5;
`endif

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [TLB_WAYS-1:0]   r_vld  [SETS];
  logic [WAY_W-1:0]      r_vic  [SETS];
  logic [VPN_WIDTH-1:0]  r_vpn  [SETS][TLB_WAYS];
  logic [PPN_WIDTH-1:0]  r_ppn  [SETS][TLB_WAYS];
  logic [PERM_W-1:0]     r_perm [SETS][TLB_WAYS];
`ifdef MMU_TLB_ASID_EN
  logic [ASID_WIDTH-1:0] r_asid [SETS][TLB_WAYS];
  logic                  r_fl_all;
  logic [ASID_WIDTH-1:0] r_fl_asid;
`endif
  logic [SET_W-1:0]      r_fl_idx;

  logic                  r_resp_valid, r_resp_hit, r_resp_fault;
  logic [PPN_WIDTH-1:0]  r_resp_ppn;
  logic [3:0]            r_resp_type;

  logic                  w_idle, w_lk_rdy, w_fill_rdy, w_lk_acc, w_fill_acc, w_flush_start;
  logic [SET_W-1:0]      w_lk_set, w_fill_set;
  logic [TLB_WAYS-1:0]   w_lk_match, w_fill_match, w_flush_clr;
  logic                  w_hit;
  logic [PPN_WIDTH-1:0]  w_hit_ppn;
  logic [PERM_W-1:0]     w_hit_perm, w_fill_perm;
  logic [3:0]            w_type;
  logic [WAY_W-1:0]      w_fill_way, w_vic_nxt;
  logic                  w_use_vic;
  logic                  w_unused;

  assign w_idle        = (r_state == IDLE);
  assign w_lk_rdy      = w_idle && !tlb.fill_valid_i && !tlb.flush_valid_i;
  assign w_fill_rdy    = w_idle && !tlb.flush_valid_i;
  assign w_lk_acc      = tlb.lookup_valid_i && w_lk_rdy;
  assign w_fill_acc    = tlb.fill_valid_i && w_fill_rdy;
  assign w_flush_start = w_idle && tlb.flush_valid_i;
  assign w_lk_set      = SET_W'(tlb.lookup_vpn_i & VPN_WIDTH'(SETS - 1));
  assign w_fill_set    = SET_W'(tlb.fill_vpn_i & VPN_WIDTH'(SETS - 1));

`ifdef MMU_TLB_ASID_EN
  assign w_fill_perm = {tlb.fill_perm_i[5], tlb.fill_perm_i[7], tlb.fill_perm_i[4:1]};
  assign w_unused    = tlb.fill_perm_i[6];
`else
  assign w_fill_perm = {tlb.fill_perm_i[7], tlb.fill_perm_i[4:1]};
  assign w_unused    = ^{tlb.fill_perm_i[6:5], tlb.flush_all_i, tlb.flush_asid_i,
                         tlb.lookup_asid_i, tlb.fill_asid_i};
`endif

  always_comb begin
    w_lk_match   = '0;
    w_fill_match = '0;
    w_flush_clr  = '0;
    for (int unsigned w = 0; w < TLB_WAYS; w++) begin
      w_lk_match[w]   = r_vld[w_lk_set][w] && (r_vpn[w_lk_set][w] == tlb.lookup_vpn_i);
      w_fill_match[w] = r_vld[w_fill_set][w] && (r_vpn[w_fill_set][w] == tlb.fill_vpn_i);
`ifdef MMU_TLB_ASID_EN
      w_lk_match[w]   = w_lk_match[w] && (r_perm[w_lk_set][w][P_G] ||
                        (r_asid[w_lk_set][w] == tlb.lookup_asid_i));
      w_fill_match[w] = w_fill_match[w] && (r_asid[w_fill_set][w] == tlb.fill_asid_i);
      w_flush_clr[w]  = r_fl_all || ((r_asid[r_fl_idx][w] == r_fl_asid) &&
                        !r_perm[r_fl_idx][w][P_G]);
`else
      w_flush_clr[w]  = 1'b1;
`endif
    end
  end

  always_comb begin
    w_hit      = 1'b0;
    w_hit_ppn  = '0;
    w_hit_perm = '0;
    for (int unsigned w = 0; w < TLB_WAYS; w++) begin
      if (w_lk_match[w] && !w_hit) begin
        w_hit      = 1'b1;
        w_hit_ppn  = r_ppn[w_lk_set][w];
        w_hit_perm = r_perm[w_lk_set][w];
      end
    end
    w_type = 4'd0;
    if (w_hit) begin
      if (!w_hit_perm[P_U] && tlb.lookup_user_i)                              w_type = 4'd4;
      else if (tlb.lookup_is_fetch_i && !w_hit_perm[P_X])                     w_type = 4'd1;
      else if (tlb.lookup_is_write_i && (!w_hit_perm[P_W] || !w_hit_perm[P_D])) w_type = 4'd2;
      else if (!tlb.lookup_is_fetch_i && !tlb.lookup_is_write_i && !w_hit_perm[P_R])
                                                                              w_type = 4'd3;
    end
  end

  // w_use_vic doubles as "no way chosen yet": matching way, then first invalid, then victim.
  always_comb begin
    w_fill_way = r_vic[w_fill_set];
    w_use_vic  = 1'b1;
    for (int unsigned w = 0; w < TLB_WAYS; w++) begin
      if (w_use_vic && w_fill_match[w]) begin
        w_fill_way = WAY_W'(w);
        w_use_vic  = 1'b0;
      end
    end
    for (int unsigned w = 0; w < TLB_WAYS; w++) begin
      if (w_use_vic && !r_vld[w_fill_set][w]) begin
        w_fill_way = WAY_W'(w);
        w_use_vic  = 1'b0;
      end
    end
    w_vic_nxt = (r_vic[w_fill_set] == WAY_W'(TLB_WAYS - 1)) ? '0 : r_vic[w_fill_set] + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (tlb.flush_valid_i) w_state_nxt = FLUSH;
      FLUSH:   if (r_fl_idx == SET_W'(SETS - 1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        r_vld[s] <= '0;
        r_vic[s] <= '0;
      end
      r_fl_idx     <= '0;
`ifdef MMU_TLB_ASID_EN
      r_fl_all     <= 1'b0;
      r_fl_asid    <= '0;
`endif
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_ppn   <= '0;
      r_resp_fault <= 1'b0;
      r_resp_type  <= '0;
    end else begin
      r_resp_valid <= w_lk_acc;
      r_resp_hit   <= w_lk_acc && w_hit;
      r_resp_ppn   <= (w_lk_acc && w_hit) ? w_hit_ppn : '0;
      r_resp_type  <= w_lk_acc ? w_type : 4'd0;
      r_resp_fault <= w_lk_acc && (w_type != 4'd0);
      if (w_flush_start) begin
        r_fl_idx  <= '0;
`ifdef MMU_TLB_ASID_EN
        r_fl_all  <= tlb.flush_all_i;
        r_fl_asid <= tlb.flush_asid_i;
`endif
      end else if (r_state == FLUSH) begin
        r_fl_idx <= r_fl_idx + 1'b1;
        r_vld[r_fl_idx] <= r_vld[r_fl_idx] & ~w_flush_clr;
      end
      if (w_fill_acc) begin
        r_vld[w_fill_set][w_fill_way] <= tlb.fill_perm_i[0];
        if (w_use_vic) r_vic[w_fill_set] <= w_vic_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fill_acc) begin
      r_vpn[w_fill_set][w_fill_way]  <= tlb.fill_vpn_i;
      r_ppn[w_fill_set][w_fill_way]  <= tlb.fill_ppn_i;
      r_perm[w_fill_set][w_fill_way] <= w_fill_perm;
`ifdef MMU_TLB_ASID_EN
      r_asid[w_fill_set][w_fill_way] <= tlb.fill_asid_i;
`endif
    end
  end

  assign tlb.lookup_ready_o    = w_lk_rdy;
  assign tlb.fill_ready_o      = w_fill_rdy;
  assign tlb.flush_done_o      = (r_state == DONE);
  assign tlb.resp_valid_o      = r_resp_valid;
  assign tlb.resp_hit_o        = r_resp_hit;
  assign tlb.resp_ppn_o        = r_resp_ppn;
  assign tlb.resp_fault_o      = r_resp_fault;
  assign tlb.resp_fault_type_o = r_resp_type;
endmodule

// File: doc/mmu_tlb.md
MMU_TLB -- requirements
Module: mmu_tlb

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 16, total entries (power of 2, multiple of TLB_WAYS).
REQ-002 SHALL have parameter TLB_WAYS, default 2, associativity (1..TLB_ENTRIES); SETS=TLB_ENTRIES/TLB_WAYS; IDX_W=$clog2(SETS), 0 when fully associative.
REQ-003 SHALL have parameters VPN_WIDTH 20, PPN_WIDTH 20, ASID_WIDTH 9: page-number and address-space-ID widths.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset. One clock; reset is asynchronous and active-high.
REQ-005 SHALL have lookup ports: lookup_valid_i in 1; lookup_ready_o out 1; lookup_vpn_i in VPN_WIDTH; lookup_asid_i in ASID_WIDTH; lookup_is_write_i in 1; lookup_is_fetch_i in 1; lookup_user_i in 1 (U-mode access).
REQ-006 SHALL have response ports: resp_valid_o out 1; resp_hit_o out 1; resp_ppn_o out PPN_WIDTH; resp_fault_o out 1; resp_fault_type_o out 4.
REQ-007 SHALL have fill ports: fill_valid_i in 1; fill_ready_o out 1; fill_vpn_i in VPN_WIDTH; fill_ppn_i in PPN_WIDTH; fill_asid_i in ASID_WIDTH; fill_perm_i in 8 ({D,A,G,U,R,W,X,V}, MSB first).
REQ-008 SHALL have flush ports: flush_valid_i in 1; flush_all_i in 1; flush_asid_i in ASID_WIDTH; flush_done_o out 1.

Function
REQ-009 SHALL use set index vpn[IDX_W-1:0] and compare the full VPN per way.
REQ-010 SHALL accept a lookup on lookup_valid_i&&lookup_ready_o and present its response exactly 1 cycle later, with resp_valid_o a 1-cycle pulse.
REQ-011 SHALL define a hit as V=1, VPN equal, and (G=1 or ASID equal); at most one way hits; resp_ppn_o = hit way PPN, else 0.
REQ-012 SHALL check faults on a hit in this priority: U=0&&lookup_user_i -> type 4; fetch&&X=0 -> type 1; write&&(W=0||D=0) -> type 2; !fetch&&!write&&R=0 -> type 3; resp_fault_o=1 iff type!=0.
REQ-013 SHALL return a miss as hit=0, fault=0, type=0, ppn=0.
REQ-014 SHALL write a fill in the acceptance cycle (fill_valid_i&&fill_ready_o); the entry is visible to lookups from the next cycle, with no same-cycle bypass.
REQ-015 SHALL select the fill way as: a way matching VPN+ASID (overwrite); else the lowest-index invalid way; else the per-set round-robin victim pointer, which then advances mod TLB_WAYS.
REQ-016 SHALL use FSM states IDLE, FLUSH, DONE: IDLE->FLUSH on flush_valid_i; FLUSH visits one set per cycle, sets 0..SETS-1, then ->DONE; DONE pulses flush_done_o for 1 cycle ->IDLE.
REQ-017 SHALL, during flush, clear V where flush_all_i=1, or where ASID==flush_asid_i and G=0; flush_all_i/flush_asid_i are captured at flush start.
REQ-018 SHALL drive lookup_ready_o = (state==IDLE)&&!fill_valid_i&&!flush_valid_i and fill_ready_o = (state==IDLE)&&!flush_valid_i; priority flush > fill > lookup.
REQ-019 SHALL complete a lookup accepted in the cycle before flush start with a response computed on pre-flush contents.

Reset
REQ-020 SHALL, on rst_i, immediately clear all V bits and victim pointers, set state to IDLE, and drive resp_*=0 and flush_done_o=0.
REQ-021 SHALL abandon a flush or pending response on reset mid-operation; no resp_valid_o or flush_done_o follows reset.
REQ-022 SHALL drive lookup_ready_o and fill_ready_o to 1 while in reset and after it, absent flush_valid_i and fill_valid_i.

Configuration
REQ-023 SHALL, with MMU_TLB_ASID_EN defined, implement ASID tag storage, ASID matching and ASID-selective flush as above.
REQ-024 SHALL, without MMU_TLB_ASID_EN, keep the ASID ports but ignore them: no ASID storage, all entries treated as G=1 for matching, and every flush behaves as flush_all_i=1.

Verification
REQ-025 SHALL verify: fill vpn=0x12345, ppn=0xABCDE, perm=0x3F (D=0,A=0,G=1,U=1,R=1,W=1,X=1,V=1), asid=3; then read lookup vpn=0x12345, asid=7 -> next cycle hit=1, ppn=0xABCDE, fault=0.
REQ-026 SHALL verify: same entry, write lookup -> hit=1, fault=1, type=2 (D=0); fetch lookup with perm X=0 -> type=1.
REQ-027 SHALL verify: WAYS=2, three fills to set 0 with distinct VPNs -> third fill evicts way 0, fourth evicts way 1; lookup of the first VPN misses.
REQ-028 SHALL verify: entries asid=1 G=0, asid=2 G=0, asid=1 G=1; flush asid=1 -> flush_done_o exactly SETS+1 cycles after request; only the G=0 asid-1 entry misses afterwards.
REQ-029 SHALL verify: fill_valid_i and lookup_valid_i in the same cycle -> lookup_ready_o=0, fill written; the retried lookup hits.
REQ-030 SHALL verify: rst_i asserted mid-flush -> all lookups miss, flush_done_o never pulses, ready signals=1.
